// File: rtl/fastio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fastio_pkg
// Description : Shared constants for the fastio pad controller: register
//               indices inside the Wishbone window, the window geometry and a
//               byte-enable expansion helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fastio_pkg;

    // Register window: 32 bytes, eight 32-bit registers
    localparam int unsigned WINDOW_BYTES = 32;
    localparam int unsigned WINDOW_AW    = $clog2(WINDOW_BYTES);

    // Register indices (word address inside the window)
    localparam logic [2:0] REG_OUT      = 3'd0;
    localparam logic [2:0] REG_OE       = 3'd1;
    localparam logic [2:0] REG_STRONG   = 3'd2;
    localparam logic [2:0] REG_MED      = 3'd3;
    localparam logic [2:0] REG_IN       = 3'd4;
    localparam logic [2:0] REG_IRQ_EN   = 3'd5;
    localparam logic [2:0] REG_IRQ_STAT = 3'd6;
    localparam logic [2:0] REG_OUT_TGL  = 3'd7;

    // Expand four byte enables into a 32-bit bit mask
    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        byte_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fastio_sync.sv
`default_nettype none
// ============================================================================
// Module      : fastio_sync
// Description : Two-flop synchronizer for asynchronous pad inputs, reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module fastio_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Metastability chain: first flop may go metastable, second resolves it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/fastio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fastio_ctrl
// Description : Wishbone-classic slave controlling NUM_IO fast pads: output
//               data, output enable, drive strength, synchronized input
//               readback, and optional rising-edge interrupts.
//               Optional feature macro: FASTIO_IRQ_EN (edge detect, IRQ_EN,
//               IRQ_STAT and fastio_irq; when undefined those registers read
//               0 and fastio_irq is tied low).
// Revision    : 1.0 - initial release
// ============================================================================
module fastio_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NUM_IO    = 28
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [NUM_IO-1:0] fastio_in,
    output logic [NUM_IO-1:0] fastio_out_l,
    output logic [NUM_IO-1:0] fastio_oe_l,
    output logic [NUM_IO-1:0] fastio_strong_enable,
    output logic [NUM_IO-1:0] fastio_med_enable,
    output logic              fastio_irq
);
    import fastio_pkg::*;

    // OUT and OE are held inverted so the pad pins come straight off flops
    // and reset naturally to all-ones (tristated).
    logic [NUM_IO-1:0] out_l_q,  out_l_d;
    logic [NUM_IO-1:0] oe_l_q,   oe_l_d;
    logic [NUM_IO-1:0] strong_q, strong_d;
    logic [NUM_IO-1:0] med_q,    med_d;
    logic              ack_q,    ack_d;
    logic [31:0]       dat_q,    dat_d;

    logic [NUM_IO-1:0] pad_sync;
    logic              hit;
    logic              take;
    logic              wr;
    logic [2:0]        reg_idx;
    logic [31:0]       wmask32;
    logic [NUM_IO-1:0] wmask;
    logic [NUM_IO-1:0] wdata;
    logic [31:0]       rdata;
    logic              w_unused;

`ifdef FASTIO_IRQ_EN
    logic [NUM_IO-1:0] prev_q;
    logic [NUM_IO-1:0] en_q,   en_d;
    logic [NUM_IO-1:0] stat_q, stat_d;
    logic [NUM_IO-1:0] rise;
    logic              irq_q;
`endif

    fastio_sync #(
        .WIDTH (NUM_IO)
    ) u_sync (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .d_i   (fastio_in),
        .q_o   (pad_sync)
    );

    // Address decode; a cycle is accepted only while no ack is outstanding
    assign hit     = wbs_stb_i & wbs_cyc_i &
                     (wbs_adr_i[31:WINDOW_AW] == BASE_ADDR[31:WINDOW_AW]);
    assign take    = hit & ~ack_q;
    assign wr      = take & wbs_we_i;
    assign reg_idx = wbs_adr_i[4:2];
    assign wmask32 = byte_mask(wbs_sel_i);
    assign wmask   = wmask32[NUM_IO-1:0];
    assign wdata   = wbs_dat_i[NUM_IO-1:0];

    // Bits outside the pad range and the byte-lane address bits are unused
    assign w_unused = ^{wbs_adr_i[1:0], wbs_dat_i, wmask32};

    // Read mux, pad-register next state and bus response
    always_comb begin
        out_l_d  = out_l_q;
        oe_l_d   = oe_l_q;
        strong_d = strong_q;
        med_d    = med_q;
        rdata    = '0;
        case (reg_idx)
            REG_OUT:      rdata[NUM_IO-1:0] = ~out_l_q;
            REG_OE:       rdata[NUM_IO-1:0] = ~oe_l_q;
            REG_STRONG:   rdata[NUM_IO-1:0] = strong_q;
            REG_MED:      rdata[NUM_IO-1:0] = med_q;
            REG_IN:       rdata[NUM_IO-1:0] = pad_sync;
`ifdef FASTIO_IRQ_EN
            REG_IRQ_EN:   rdata[NUM_IO-1:0] = en_q;
            REG_IRQ_STAT: rdata[NUM_IO-1:0] = stat_q;
`endif
            default:      rdata = '0;
        endcase
        if (wr) begin
            case (reg_idx)
                REG_OUT:     out_l_d  = (out_l_q & ~wmask) | (~wdata & wmask);
                REG_OE:      oe_l_d   = (oe_l_q & ~wmask) | (~wdata & wmask);
                REG_STRONG:  strong_d = (strong_q & ~wmask) | (wdata & wmask);
                REG_MED:     med_d    = (med_q & ~wmask) | (wdata & wmask);
                REG_OUT_TGL: out_l_d  = out_l_q ^ (wdata & wmask);
                default:     ;
            endcase
        end
        ack_d = take;
        dat_d = take ? rdata : 32'h0;
    end

    // Bus and pad-control registers; reset aborts any transfer in flight
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            out_l_q  <= '1;
            oe_l_q   <= '1;
            strong_q <= '0;
            med_q    <= '0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            out_l_q  <= out_l_d;
            oe_l_q   <= oe_l_d;
            strong_q <= strong_d;
            med_q    <= med_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
        end
    end

`ifdef FASTIO_IRQ_EN
    assign rise = pad_sync & ~prev_q;

    // Interrupt registers; an edge set overrides a simultaneous W1C clear
    always_comb begin
        en_d   = en_q;
        stat_d = stat_q;
        if (wr && (reg_idx == REG_IRQ_EN)) begin
            en_d = (en_q & ~wmask) | (wdata & wmask);
        end
        if (wr && (reg_idx == REG_IRQ_STAT)) begin
            stat_d = stat_q & ~(wdata & wmask);
        end
        stat_d = stat_d | rise;
    end

    // Edge history, interrupt state and registered interrupt line
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            prev_q <= '0;
            en_q   <= '0;
            stat_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            prev_q <= pad_sync;
            en_q   <= en_d;
            stat_q <= stat_d;
            irq_q  <= |(stat_q & en_q);
        end
    end

    assign fastio_irq = irq_q;
`else
    assign fastio_irq = 1'b0;
`endif

    assign wbs_ack_o            = ack_q;
    assign wbs_dat_o            = dat_q;
    assign fastio_out_l         = out_l_q;
    assign fastio_oe_l          = oe_l_q;
    assign fastio_strong_enable = strong_q;
    assign fastio_med_enable    = med_q;

endmodule
`default_nettype wire

// File: tb/tb_fastio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fastio_ctrl
// Description : Self-checking bench for fastio_ctrl. Reads are predicted from
//               a register-level model and queued; a monitor pops and compares
//               on every ack. Pad pins and the interrupt line are compared
//               against the same model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fastio_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          NIO  = 28;
    localparam logic [31:0] MASK = 32'h0FFF_FFFF;

    logic           wb_clk_i = 1'b0;
    logic           wb_rst_i;
    logic           wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]     wbs_sel_i;
    logic [31:0]    wbs_adr_i, wbs_dat_i;
    logic           wbs_ack_o;
    logic [31:0]    wbs_dat_o;
    logic [NIO-1:0] fastio_in;
    logic [NIO-1:0] fastio_out_l, fastio_oe_l, fastio_strong_enable, fastio_med_enable;
    logic           fastio_irq;

    fastio_ctrl #(.BASE_ADDR(BASE), .NUM_IO(NIO)) dut (
        .wb_clk_i             (wb_clk_i),
        .wb_rst_i             (wb_rst_i),
        .wbs_stb_i            (wbs_stb_i),
        .wbs_cyc_i            (wbs_cyc_i),
        .wbs_we_i             (wbs_we_i),
        .wbs_sel_i            (wbs_sel_i),
        .wbs_adr_i            (wbs_adr_i),
        .wbs_dat_i            (wbs_dat_i),
        .wbs_ack_o            (wbs_ack_o),
        .wbs_dat_o            (wbs_dat_o),
        .fastio_in            (fastio_in),
        .fastio_out_l         (fastio_out_l),
        .fastio_oe_l          (fastio_oe_l),
        .fastio_strong_enable (fastio_strong_enable),
        .fastio_med_enable    (fastio_med_enable),
        .fastio_irq           (fastio_irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int total = 0;
    int bad   = 0;

    // Scoreboard: one entry per expected ack
    logic [31:0] exp_q[$];
    bit          chk_q[$];
    int          idx_q[$];

    // Register-level model of the visible state
    logic [31:0] m_out, m_oe, m_str, m_med, m_en, m_stat, m_pad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] idx);
        case (idx)
            3'd0:    return m_out;
            3'd1:    return m_oe;
            3'd2:    return m_str;
            3'd3:    return m_med;
            3'd4:    return m_pad;
            3'd5:    return m_en;
            3'd6:    return m_stat;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [2:0] idx, input logic [3:0] sel, input logic [31:0] dat);
        logic [31:0] bm;
        logic [31:0] v;
        bm = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}} & MASK;
        v  = dat & bm;
        case (idx)
            3'd0: m_out = (m_out & ~bm) | v;
            3'd1: m_oe  = (m_oe  & ~bm) | v;
            3'd2: m_str = (m_str & ~bm) | v;
            3'd3: m_med = (m_med & ~bm) | v;
`ifdef FASTIO_IRQ_EN
            3'd5: m_en   = (m_en & ~bm) | v;
            3'd6: m_stat = m_stat & ~v;
`endif
            3'd7: m_out = m_out ^ v;
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_out = 0; m_oe = 0; m_str = 0; m_med = 0; m_en = 0; m_stat = 0;
    endtask

    // One in-window transfer; the expected response is queued for the monitor
    task automatic wb(input bit we, input logic [2:0] idx, input logic [3:0] sel, input logic [31:0] dat);
        @(posedge wb_clk_i); #1;
        exp_q.push_back(model_read(idx));
        chk_q.push_back(!we);
        idx_q.push_back(int'(idx));
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = we;
        wbs_adr_i = BASE + {27'h0, idx, 2'b00};
        wbs_sel_i = sel; wbs_dat_i = dat;
        @(posedge wb_clk_i);
        if (we) model_write(idx, sel, dat);
        @(negedge wb_clk_i);
        chk("ack_latency", {31'h0, wbs_ack_o}, 32'h1);
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
    endtask

    // Held strobe to an address outside the window: never acknowledged
    task automatic wb_outside(input logic [31:0] adr);
        int n;
        n = 0;
        @(posedge wb_clk_i); #1;
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 1;
        wbs_adr_i = adr; wbs_sel_i = 4'hF; wbs_dat_i = $urandom();
        repeat (10) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o) n++;
        end
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
        chk("outside_acks", n, 0);
    endtask

    task automatic set_pads(input logic [31:0] v);
        @(posedge wb_clk_i); #1;
`ifdef FASTIO_IRQ_EN
        m_stat = m_stat | (v & ~m_pad & MASK);
`endif
        m_pad     = v & MASK;
        fastio_in = v[NIO-1:0];
        repeat (6) @(posedge wb_clk_i);
    endtask

    task automatic check_pins();
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("pin_out_l",  {4'h0, fastio_out_l},         ~m_out & MASK);
        chk("pin_oe_l",   {4'h0, fastio_oe_l},          ~m_oe & MASK);
        chk("pin_strong", {4'h0, fastio_strong_enable}, m_str);
        chk("pin_med",    {4'h0, fastio_med_enable},    m_med);
        chk("pin_irq",    {31'h0, fastio_irq},          {31'h0, |(m_stat & m_en)});
    endtask

    task automatic read_all();
        for (int r = 0; r < 8; r++) wb(1'b0, 3'(r), 4'hF, 32'h0);
    endtask

    // Monitor: checks every ack against the scoreboard and idle bus behaviour
    initial begin
        logic        prev_ack;
        logic [31:0] e;
        bit          c;
        int          ix;
        prev_ack = 1'b0;
        forever begin
            @(negedge wb_clk_i);
            if (wbs_ack_o === 1'b1) begin
                chk("ack_single_pulse", {31'h0, prev_ack}, 32'h0);
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_ack actual=1 required=0 at %0t", $time);
                end else begin
                    e  = exp_q.pop_front();
                    c  = chk_q.pop_front();
                    ix = idx_q.pop_front();
                    if (c) chk($sformatf("read_reg%0d", ix), wbs_dat_o, e);
                end
            end else begin
                chk("idle_dat_zero", wbs_dat_o, 32'h0);
            end
            prev_ack = wbs_ack_o;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        wb_rst_i = 1; wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
        wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0; fastio_in = '0;
        model_reset(); m_pad = 0;
        repeat (3) @(posedge wb_clk_i);
        #1 wb_rst_i = 0;

        // Reset state
        @(negedge wb_clk_i);
        chk("rst_out_l", {4'h0, fastio_out_l}, 32'h0FFF_FFFF);
        chk("rst_oe_l",  {4'h0, fastio_oe_l},  32'h0FFF_FFFF);
        chk("rst_ack",   {31'h0, wbs_ack_o},   32'h0);
        check_pins();
        wb(1'b0, 3'd0, 4'hF, 32'h0);

        // Byte-lane writes to OUT, enable pads
        wb(1'b1, 3'd0, 4'b0001, 32'h0000_00A5);
        wb(1'b1, 3'd1, 4'hF,    32'h0000_0001);
        check_pins();
        chk("out_l_low_byte", {24'h0, fastio_out_l[7:0]}, 32'h0000_005A);
        wb(1'b1, 3'd0, 4'b0010, 32'hFFFF_FF00);
        wb(1'b0, 3'd0, 4'hF, 32'h0);

        // Toggle register
        wb(1'b1, 3'd0, 4'hF, 32'h0000_0001);
        wb(1'b1, 3'd7, 4'hF, 32'h0000_0003);
        wb(1'b0, 3'd0, 4'hF, 32'h0);
        wb(1'b0, 3'd7, 4'hF, 32'h0);
        check_pins();

        // Upper bits beyond the pad range read back as zero
        wb(1'b1, 3'd2, 4'hF, 32'hFFFF_FFFF);
        wb(1'b0, 3'd2, 4'hF, 32'h0);
        wb(1'b1, 3'd4, 4'hF, 32'h1234_5678);
        wb(1'b0, 3'd4, 4'hF, 32'h0);

`ifdef FASTIO_IRQ_EN
        // Interrupt: edge on pad 2, then W1C
        wb(1'b1, 3'd5, 4'hF, 32'h0000_0004);
        @(posedge wb_clk_i); #1;
        fastio_in[2] = 1'b1; m_pad = m_pad | 32'h4; m_stat = m_stat | 32'h4;
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge wb_clk_i); #1;
            if (fastio_irq && n == 0) n = i;
        end
        chk("irq_latency", n, 4);
        wb(1'b0, 3'd6, 4'hF, 32'h0);
        wb(1'b1, 3'd6, 4'hF, 32'h0000_0004);
        check_pins();

        // Collision: W1C lands on the edge that sets bit 2
        set_pads(m_pad & ~32'h4);
        @(posedge wb_clk_i); #1;
        fastio_in[2] = 1'b1; m_pad = m_pad | 32'h4;
        @(posedge wb_clk_i);
        wb(1'b1, 3'd6, 4'hF, 32'h0000_0004);
        m_stat = m_stat | 32'h4;
        wb(1'b0, 3'd6, 4'hF, 32'h0);
        check_pins();
`else
        // Interrupt registers absent: they read 0 and ignore writes
        wb(1'b1, 3'd5, 4'hF, 32'h0000_0004);
        set_pads(m_pad | 32'h4);
        wb(1'b1, 3'd6, 4'hF, 32'hFFFF_FFFF);
        wb(1'b0, 3'd5, 4'hF, 32'h0);
        wb(1'b0, 3'd6, 4'hF, 32'h0);
        check_pins();
`endif

        // Outside the window: no ack, no state change
        wb_outside(BASE + 32'h20);
        read_all();

        // Reset on the edge that samples a write: aborted
        @(posedge wb_clk_i); #1;
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 1;
        wbs_adr_i = BASE; wbs_sel_i = 4'hF; wbs_dat_i = 32'h0ABC_DEF1;
        @(negedge wb_clk_i);
        wb_rst_i = 1;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("rst_abort_ack", {31'h0, wbs_ack_o}, 32'h0);
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
        repeat (2) @(posedge wb_clk_i);
        #1 wb_rst_i = 0;
        model_reset();
`ifdef FASTIO_IRQ_EN
        m_stat = m_pad;
`endif
        repeat (6) @(posedge wb_clk_i);
        check_pins();
        read_all();

        // Randomized traffic against the model
        for (int k = 0; k < 150; k++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 3)      wb(1'b1, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom());
            else if (op <= 6) wb(1'b0, 3'($urandom_range(0, 7)), 4'hF, 32'h0);
            else if (op == 7) set_pads($urandom());
            else if (op == 8) wb_outside(BASE ^ (32'h1 << $urandom_range(5, 31)));
            else              check_pins();
        end
        read_all();
        check_pins();

        repeat (4) @(posedge wb_clk_i);
        chk("pending_acks", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
